// File: rtl/rs_dec_pkg.sv
// Shared RS(32,28) decoder constants and the syndrome sequencer state encoding.
package rs_dec_pkg;
  localparam int RS_N        = 32;
  localparam int RS_K        = 28;
  localparam int SC_HOLD_CYC = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_COLLECT,
    ST_SETTLE,
    ST_CAPTURE
  } sc_state_e;
endpackage

// File: rtl/rs_dec_syndrome_ctrl.sv
// Frame sequencer for the RS(32,28) syndrome calculator: clears it per frame, paces
// symbols onto its toggle-synchronised input and hands S0..S3 downstream.
module rs_dec_syndrome_ctrl
  import rs_dec_pkg::*;
#(
  parameter int N_SYM    = RS_N,
  parameter int HOLD_CYC = SC_HOLD_CYC
) (
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_frame_sync,
  input  logic [7:0] i_byte,
  input  logic       i_byte_vld,
  output logic       o_byte_rdy,
  output logic       o_sc_resb,
  output logic [7:0] o_sc_data,
  output logic       o_sc_data_sync,
  input  logic [7:0] i_s0,
  input  logic [7:0] i_s1,
  input  logic [7:0] i_s2,
  input  logic [7:0] i_s3,
  output logic [7:0] o_synd0,
  output logic [7:0] o_synd1,
  output logic [7:0] o_synd2,
  output logic [7:0] o_synd3,
  output logic       o_synd_vld,
  input  logic       i_synd_ack,
  output logic       o_err,
  output logic       o_short_frame,
  output logic       o_overrun
);
  localparam int SW = $clog2(N_SYM);
  localparam int HW = $clog2(HOLD_CYC + 1);

  sc_state_e     state, state_nxt;
  logic [SW-1:0] sym_cnt;
  logic [HW-1:0] hold_cnt;
  logic          accept, short_nxt;

  assign accept = o_byte_rdy & i_byte_vld;

  always_comb begin
    state_nxt  = state;
    o_byte_rdy = 1'b0;
    short_nxt  = 1'b0;
    case (state)
      ST_IDLE:    if (i_frame_sync) state_nxt = ST_CLR;
      ST_CLR:     state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (i_frame_sync) begin
          state_nxt = ST_CLR;
          short_nxt = (sym_cnt != '0);
        end else begin
          o_byte_rdy = (hold_cnt == '0);
          if (o_byte_rdy && i_byte_vld && sym_cnt == SW'(N_SYM - 1)) state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (i_frame_sync) begin
          state_nxt = ST_CLR;
          short_nxt = (sym_cnt != '0);
        end else if (hold_cnt == '0) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_nxt = i_frame_sync ? ST_CLR : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state          <= ST_IDLE;
      sym_cnt        <= '0;
      hold_cnt       <= '0;
      o_sc_resb      <= 1'b1;
      o_sc_data      <= '0;
      o_sc_data_sync <= 1'b0;
      o_synd0        <= '0;
      o_synd1        <= '0;
      o_synd2        <= '0;
      o_synd3        <= '0;
      o_synd_vld     <= 1'b0;
      o_err          <= 1'b0;
      o_short_frame  <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      state         <= state_nxt;
      // Clear lands one cycle after CLR so it also swallows the pending accumulate
      // of a symbol toggled just before an aborting frame sync.
      o_sc_resb     <= (state != ST_CLR);
      o_short_frame <= short_nxt;

      // Last symbol leaves sym_cnt at N_SYM-1 so SETTLE still reads as a partial frame.
      if (state == ST_CLR)
        sym_cnt <= '0;
      else if (accept && sym_cnt != SW'(N_SYM - 1))
        sym_cnt <= sym_cnt + 1'b1;

      // hold_cnt keeps counting through CLR: an abort must not shorten the hold window.
      if (accept) begin
        hold_cnt       <= HW'(HOLD_CYC - 1);
        o_sc_data      <= i_byte;
        o_sc_data_sync <= ~o_sc_data_sync;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end

      if (state == ST_CAPTURE) begin
        o_synd0    <= i_s0;
        o_synd1    <= i_s1;
        o_synd2    <= i_s2;
        o_synd3    <= i_s3;
        o_err      <= |{i_s0, i_s1, i_s2, i_s3};
        o_synd_vld <= 1'b1;
        if (o_synd_vld && !i_synd_ack) o_overrun <= 1'b1;
      end else if (i_synd_ack) begin
        o_synd_vld <= 1'b0;
      end
    end
  end
endmodule
